// File: rtl/scarv_cop_pmul_iter.sv
// scarv_cop_pmul_iter
// Iterative packed multiplier. It computes one shift-add (or shift-xor) step
// per cycle in every lane at once. The integer add goes through the shared
// packed adder (padd_*). The carry-less XOR is done locally.
//
// Ports
//   g_clk, g_resetn      clock, async active-low reset
//   valid / ready        request (held until ready) / one-cycle result strobe
//   mul_l, mul_h         half select (mul_l wins; neither = low half)
//   clmul                1 = carry-less product, 0 = integer product
//   pw                   one-hot pack width, pw[0]=32-bit lane .. pw[4]=2-bit lanes
//   crs1, crs2           packed multiplicand / multiplier
//   result               packed result half, valid while ready=1, else 0
//   padd_lhs/rhs/pw/sub  shared adder request, driven only while iterating
//   padd_result/carry    shared adder response (combinational, same cycle)
//
// state  | meaning
// S_IDLE | waiting for valid; operands are latched on acceptance
// S_ITER | one partial-product step per cycle, W cycles
// S_DONE | ready=1 and result presented for exactly one cycle
module scarv_cop_pmul_iter (
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic        valid,
   output logic        ready,
   input  logic        mul_l,
   input  logic        mul_h,
   input  logic        clmul,
   input  logic [4:0]  pw,
   input  logic [31:0] crs1,
   input  logic [31:0] crs2,
   output logic [31:0] result,
   output logic [31:0] padd_lhs,
   output logic [31:0] padd_rhs,
   output logic [4:0]  padd_pw,
   output logic        padd_sub,
   input  logic [31:0] padd_carry,
   input  logic [31:0] padd_result
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_DONE = 2'd2} state_t;

   // Any pw that is not exactly one-hot is treated as a single 32-bit lane.
   function automatic logic [4:0] norm_pw(input logic [4:0] p);
      case (p)
         5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000: norm_pw = p;
         default:                                          norm_pw = 5'b00001;
      endcase
   endfunction

   // Lane width minus one
   function automatic logic [4:0] lane_wm(input logic [4:0] p);
      case (p)
         5'b00010: lane_wm = 5'd15;
         5'b00100: lane_wm = 5'd7;
         5'b01000: lane_wm = 5'd3;
         5'b10000: lane_wm = 5'd1;
         default:  lane_wm = 5'd31;
      endcase
   endfunction

   // One bit set at the least significant bit of every lane
   function automatic logic [31:0] lane_lsb(input logic [4:0] p);
      case (p)
         5'b00010: lane_lsb = 32'h0001_0001;
         5'b00100: lane_lsb = 32'h0101_0101;
         5'b01000: lane_lsb = 32'h1111_1111;
         5'b10000: lane_lsb = 32'h5555_5555;
         default:  lane_lsb = 32'h0000_0001;
      endcase
   endfunction

   state_t      state_q,  state_d;
   logic [4:0]  cnt_q,    cnt_d;
   logic [31:0] mcand_q,  mcand_d;
   logic [31:0] hi_q,     hi_d;
   logic [31:0] lo_q,     lo_d;
   logic [4:0]  pw_q,     pw_d;
   logic        clmul_q,  clmul_d;
   logic        hsel_q,   hsel_d;
   logic        ready_q,  ready_d;
   logic [31:0] result_q, result_d;

   logic [4:0]  wm;
   logic [31:0] lsb_mask;
   logic [31:0] msb_mask;
   logic [31:0] m;
   logic [31:0] sum;
   logic [31:0] lane_c;
   logic [31:0] hi_nx;
   logic [31:0] lo_nx;
   logic [4:0]  in_pw;

   // Datapath for one step. Lane boundaries come from masks, so no bit
   // ever moves from one lane into its neighbour.
   always_comb begin
      wm       = lane_wm(pw_q);
      lsb_mask = lane_lsb(pw_q);
      msb_mask = lsb_mask << wm;
      m        = '0;
      for (int i = 0; i < 32; i++) begin
         // Broadcast the multiplier bit at the lane LSB across the whole lane.
         m[i] = mcand_q[i] & lo_q[5'(i) & ~wm];
      end
      sum    = clmul_q ? (hi_q ^ m) : padd_result;
      lane_c = clmul_q ? 32'h0 : (padd_carry & msb_mask);
      hi_nx  = lane_c | (~msb_mask & (sum >> 1));
      lo_nx  = (~msb_mask & (lo_q >> 1)) | ((sum & lsb_mask) << wm);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      pw_d     = pw_q;
      clmul_d  = clmul_q;
      hsel_d   = hsel_q;
      ready_d  = 1'b0;
      result_d = '0;
      in_pw    = norm_pw(pw);
      case (state_q)
         S_IDLE: begin
            if (valid) begin
               mcand_d = crs1;
               lo_d    = crs2;
               hi_d    = '0;
               pw_d    = in_pw;
               clmul_d = clmul;
               hsel_d  = !mul_l && mul_h;
               cnt_d   = lane_wm(in_pw);
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            if (!valid) begin
               state_d = S_IDLE;
            end else begin
               hi_d = hi_nx;
               lo_d = lo_nx;
               if (cnt_q == 5'd0) begin
                  state_d  = S_DONE;
                  ready_d  = 1'b1;
                  result_d = hsel_q ? hi_nx : lo_nx;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         pw_q     <= '0;
         clmul_q  <= 1'b0;
         hsel_q   <= 1'b0;
         ready_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         pw_q     <= pw_d;
         clmul_q  <= clmul_d;
         hsel_q   <= hsel_d;
         ready_q  <= ready_d;
         result_q <= result_d;
      end
   end

   assign ready    = ready_q;
   assign result   = result_q;
   assign padd_lhs = (state_q == S_ITER) ? hi_q : 32'h0;
   assign padd_rhs = (state_q == S_ITER) ? m    : 32'h0;
   assign padd_pw  = (state_q == S_ITER) ? pw_q : 5'h0;
   assign padd_sub = 1'b0;

endmodule
